// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone B.4 pipelined arbiter with zero-latency grant.
// The owner keeps the bus while its CYC stays high; the loser is held off with STALL.
`timescale 1ns/1ps
module wb_arbiter #(
  parameter int AW    = 64,
  parameter int DW    = 16,
  parameter int SW    = 2,
  parameter int PRIO0 = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_stb_i,
  input  logic          m0_cyc_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_stb_i,
  input  logic          m1_cyc_i,
  output logic          m0_ack_o,
  output logic          m1_ack_o,
  output logic          m0_stall_o,
  output logic          m1_stall_o,
  output logic [DW-1:0] m0_dat_o,
  output logic [DW-1:0] m1_dat_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic          s_ack_i,
  input  logic          s_stall_i,
  input  logic [DW-1:0] s_dat_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } own_e;

  own_e own_q, own_d;
  logic last_q, last_d;
  logic [1:0] gnt;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      own_q  <= OWN_IDLE;
      last_q <= 1'b1;
    end else begin
      own_q  <= own_d;
      last_q <= last_d;
    end
  end

  // Held ownership wins; otherwise arbitrate the free bus in the same cycle,
  // which also gives the zero-gap handover when the owner drops CYC.
  always_comb begin
    gnt    = 2'b00;
    own_d  = OWN_IDLE;
    last_d = last_q;
    if (own_q == OWN_M0 && m0_cyc_i)
      gnt = 2'b01;
    else if (own_q == OWN_M1 && m1_cyc_i)
      gnt = 2'b10;
    else if (m0_cyc_i && m1_cyc_i)
      gnt = (PRIO0 != 0 || last_q) ? 2'b01 : 2'b10;
    else if (m0_cyc_i)
      gnt = 2'b01;
    else if (m1_cyc_i)
      gnt = 2'b10;
    if (!reset_i)
      gnt = 2'b00;
    case (gnt)
      2'b01:   own_d = OWN_M0;
      2'b10:   own_d = OWN_M1;
      default: own_d = OWN_IDLE;
    endcase
    if (gnt != 2'b00)
      last_d = gnt[1];
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (gnt[0]) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_stb_o = m0_stb_i;
      s_cyc_o = m0_cyc_i;
    end else if (gnt[1]) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_stb_o = m1_stb_i;
      s_cyc_o = m1_cyc_i;
    end
  end

  // A waiting master is stalled for as long as it requests the bus.
  assign m0_stall_o = gnt[0] ? s_stall_i : m0_cyc_i;
  assign m1_stall_o = gnt[1] ? s_stall_i : m1_cyc_i;
  assign m0_ack_o   = s_ack_i & gnt[0];
  assign m1_ack_o   = s_ack_i & gnt[1];
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign gnt_o      = gnt;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Two-master to one-slave Wishbone B.4 pipelined arbiter that sits directly downstream of the load/store unit's 16-bit master port.
Master 0 is the LSU and master 1 is the instruction fetch unit; the single slave port drives the shared 16-bit memory/IO bus.
- Grants are zero-latency when the bus is free.
- Ownership is held for the full duration of the owner's CYC.
- Losing masters are held off with STALL.

Parameters:
AW, 64, address width.
DW, 16, data width.
SW, 2, byte-select width (DW/8).
PRIO0, 1, 1 = master 0 wins simultaneous requests; 0 = round-robin on ties.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
reset_i  in  1  asynchronous, active-low reset.
m0_adr_i / m1_adr_i  in  AW  master address.
m0_dat_i / m1_dat_i  in  DW  master write data.
m0_we_i / m1_we_i  in  1  write enable.
m0_sel_i / m1_sel_i  in  SW  byte selects.
m0_stb_i / m1_stb_i  in  1  strobe.
m0_cyc_i / m1_cyc_i  in  1  cycle (bus request).
m0_ack_o / m1_ack_o  out  1  acknowledge, routed to the owner only.
m0_stall_o / m1_stall_o  out  1  stall.
m0_dat_o / m1_dat_o  out  DW  read data; s_dat_i broadcast to both.
s_adr_o  out  AW  muxed address.
s_dat_o  out  DW  muxed write data.
s_we_o  out  1  muxed write enable.
s_sel_o  out  SW  muxed byte selects.
s_stb_o  out  1  muxed strobe.
s_cyc_o  out  1  muxed cycle.
s_ack_i  in  1  slave acknowledge.
s_stall_i  in  1  slave stall.
s_dat_i  in  DW  slave read data.
gnt_o  out  2  one-hot effective grant {m1,m0}; 00 = none.

Behaviour:
- State registers:
  - own[1:0]: 00 idle, 01 m0, 10 m1.
  - last: 1 bit, identity of the previous owner.
- Reset (reset_i low, asynchronous):
  - own=00, last=1.
  - While reset is asserted, gnt_o=00; all s_* outputs and both ack_o are 0; mN_stall_o = mN_cyc_i.
- Held ownership:
  - held = (own==01 & m0_cyc_i) | (own==10 & m1_cyc_i).
  - If held, the effective grant is own.
- Free bus (no held ownership), evaluated combinationally in the same cycle:
  - Only one cyc high: that master.
  - Both high with PRIO0=1: m0.
  - Both high with PRIO0=0: the master that is not `last`.
  - Neither high: none.
- Zero-gap handover: when the owner drops cyc, the other master may be granted in that same cycle.
- Next state:
  - own <= gnt_o.
  - last <= owner index whenever gnt_o != 00.
- Slave port:
  - Carries the granted master's adr/dat/we/sel/stb/cyc verbatim.
  - All s_* outputs are 0 when no master is granted.
  - No registering, so latency is 0 cycles.
- Stall:
  - Granted master sees mN_stall_o = s_stall_i.
  - Non-granted master sees mN_stall_o = mN_cyc_i.
  - Masters must hold stb/adr/dat while stalled.
- Ack:
  - mN_ack_o = s_ack_i & gnt_o[N].
  - An ack arriving with gnt_o=00 is discarded.
- No outstanding-ack counting: the owner is responsible for holding cyc until all its acks return, as Wishbone B.4 requires.
- Simultaneous release-and-request by the same master (cyc low for one cycle, then high): treated as a new request and arbitrated normally.
- Width rule: mux only, no width conversion.

Test Plan:
- Reset: hold reset_i low with m0_cyc_i=1 -> s_cyc_o=0, gnt_o=00, m0_stall_o=1. Release reset -> same cycle gnt_o=01, s_adr_o=m0_adr_i.
- Single master: m1 issues 3 pipelined reads (adr 0x100, 0x102, 0x104); slave acks with dat 0xAAAA, 0xBBBB, 0xCCCC -> m1_ack_o pulses 3 times, m1_dat_o matches, m0_ack_o stays 0.
- Tie with PRIO0=1: m0_cyc_i and m1_cyc_i rise in the same cycle -> gnt_o=01, m1_stall_o=1 until m0 drops cyc. The next cycle gives gnt_o=10 with no idle gap.
- Round-robin with PRIO0=0: both request continuously, each releasing after 2 acks -> grants alternate 01,10,01,10, starting with 01 out of reset.
- Hold: m1 owns the bus, then m0 asserts cyc with stb and we=1, dat 0x1234 -> s_we_o tracks m1_we_i, m0_stall_o=1, and no s_stb_o is seen from m0 until m1_cyc_i falls.
- Slave stall and stray ack:
  - With the slave asserting s_stall_i=1 for 2 cycles -> the owner's stall_o=1 for exactly those cycles.
  - An s_ack_i pulse while gnt_o=00 -> both ack_o remain 0.
